// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port between the core
// writeback stage (port A, priority) and a FIFO-buffered slow unit (port B).
// Queued B writes are exported as a pending-register scoreboard.

// One FIFO entry: destination, data, and its scoreboard contribution.
module rf_wr_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [4:0]  new_rw,
  input  logic [31:0] new_data,
  output logic [4:0]  rw,
  output logic [31:0] data,
  output logic [31:0] pend
);
  logic vld;

  // Entry storage; valid resets so queued writes vanish on reset.
  // Load and clear cannot hit the same slot in one cycle: that would
  // need a push into a full FIFO or a pop from an empty one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      rw   <= '0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      rw   <= new_rw;
      data <= new_data;
    end else if (clear) begin
      vld  <= 1'b0;
    end
  end

  // One-hot of the destination while the entry is live; r0 never pends.
  always_comb begin
    pend = '0;
    if (vld) pend[rw] = 1'b1;
    pend[0] = 1'b0;
  end
endmodule

module rf_wr_arbiter #(
  parameter int QDEPTH = 4,
  parameter int STARVE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aWr,
  input  logic                       aLink,
  input  logic [4:0]                 aRw,
  input  logic [31:0]                aData,
  input  logic [31:0]                aPC,
  input  logic                       bValid,
  input  logic [4:0]                 bRw,
  input  logic [31:0]                bData,
  output logic                       bReady,
  output logic                       regWr,
  output logic                       regL,
  output logic [4:0]                 Rw,
  output logic [31:0]                busW,
  output logic [31:0]                curPC,
  output logic                       stall,
  output logic [31:0]                pending,
  output logic [$clog2(QDEPTH):0]    qCount
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] data;
  } b_req_t;

  logic [PW-1:0]                wptr, rptr;
  logic [CW-1:0]                count;
  logic [3:0]                   waitCnt;
  logic [QDEPTH-1:0][4:0]       slot_rw;
  logic [QDEPTH-1:0][31:0]      slot_data;
  logic [QDEPTH-1:0][31:0]      slot_pend;
  logic                         full, nonempty, push, pop, grant_a;
  b_req_t                       head;

  assign full     = (count == CW'(QDEPTH));
  assign nonempty = (count != '0);
  assign bReady   = !full;
  assign qCount   = count;
  assign stall    = (waitCnt == 4'(STARVE));
  // r0 pushes complete the handshake but are never queued.
  assign push     = bValid && bReady && (bRw != 5'd0);
  assign grant_a  = !stall && aWr;
  assign pop      = !grant_a && nonempty;
  assign head     = '{rw: slot_rw[rptr], data: slot_data[rptr]};

  genvar i;
  generate
    for (i = 0; i < QDEPTH; i++) begin : g_slot
      rf_wr_slot u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (push && (wptr == PW'(i))),
        .clear    (pop && (rptr == PW'(i))),
        .new_rw   (bRw),
        .new_data (bData),
        .rw       (slot_rw[i]),
        .data     (slot_data[i]),
        .pend     (slot_pend[i])
      );
    end
  endgenerate

  // Scoreboard: union of live entries' destinations.
  always_comb begin
    pending = '0;
    for (int k = 0; k < QDEPTH; k++) pending |= slot_pend[k];
  end

  // FIFO pointers/occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Starvation counter: counts cycles the head loses to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 waitCnt <= '0;
    else if (pop || !nonempty)  waitCnt <= '0;
    else if (grant_a)           waitCnt <= waitCnt + 4'd1;
  end

  // Write-port mux: A first unless stalled, then the B head, else idle.
  always_comb begin
    regWr = 1'b0;
    regL  = 1'b0;
    Rw    = '0;
    busW  = '0;
    curPC = '0;
    if (rst_n) begin
      if (grant_a) begin
        regWr = 1'b1;
        regL  = aLink;
        Rw    = aRw;
        busW  = aData;
        curPC = aPC;
      end else if (nonempty) begin
        regWr = 1'b1;
        Rw    = head.rw;
        busW  = head.data;
      end
    end
  end
endmodule
